seq_divider: RTL and testbench

- Sequential restoring unsigned divider: dividend / divisor -> quotient and remainder, one quotient bit per clock.
- Inverse companion of the pipelined DSP multiply-accumulate lab block.
- Sits between board switches/buttons and the LED bank.
- Start/busy/done handshake lets a top-level wrapper launch a division and latch the result for display.

---
 rtl/div_pkg.sv | 18 +
 rtl/div_step.sv | 23 ++
 rtl/seq_divider.sv | 116 +++++++++++
 tb/tb_seq_divider.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_t;

  localparam int unsigned DefN = 8;
  localparam int unsigned DefM = 4;

  // Width of the iteration counter that walks through the N quotient bits.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, subtract if it fits.
module div_step #(
  parameter int unsigned M = 4
) (
  input  logic [M:0]   p_i,
  input  logic         d_bit_i,
  input  logic [M-1:0] v_i,
  output logic [M:0]   p_o,
  output logic         q_o
);

  logic [M+1:0] t;
  logic [M:0]   diff;

  // The partial remainder MSB is always 0, so the full-width trial value equals {P[M-1:0], d}.
  always_comb begin
    t    = {p_i, d_bit_i};
    diff = t[M:0] - {1'b0, v_i};
    q_o  = (t >= {2'b00, v_i});
    p_o  = q_o ? diff : t[M:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned divider producing one quotient bit per clock with a start/busy/done handshake.
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned N = DefN,
  parameter int unsigned M = DefM
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [N-1:0] dividend_i,
  input  logic [M-1:0] divisor_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [N-1:0] quot_o,
  output logic [M-1:0] rem_o,
  output logic         div_zero_o
);

  localparam int unsigned CW = cnt_width(N);
  localparam logic [CW-1:0] CntLast = CW'(N - 1);

  state_t         state_q, state_d;
  logic [N-1:0]   d_q, d_d;
  logic [M-1:0]   v_q, v_d;
  logic [M:0]     p_q, p_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   quot_q, quot_d;
  logic [M-1:0]   rem_q, rem_d;
  logic           dz_q, dz_d;

  logic [M:0]     p_new;
  logic           q_bit;

  div_step #(
    .M (M)
  ) u_step (
    .p_i     (p_q),
    .d_bit_i (d_q[N-1]),
    .v_i     (v_q),
    .p_o     (p_new),
    .q_o     (q_bit)
  );

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    v_d     = v_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          d_d   = dividend_i;
          v_d   = divisor_i;
          p_d   = '0;
          cnt_d = '0;
          // Division by zero skips iteration and reports a saturated quotient.
          if (divisor_i == '0) begin
            quot_d  = '1;
            rem_d   = '0;
            dz_d    = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        d_d   = {d_q[N-2:0], q_bit};
        p_d   = p_new;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CntLast) begin
          quot_d  = {d_q[N-2:0], q_bit};
          rem_d   = p_new[M-1:0];
          dz_d    = 1'b0;
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      d_q     <= '0;
      v_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      v_q     <= v_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  assign busy_o     = (state_q == StCalc);
  assign done_o     = (state_q == StDone);
  assign quot_o     = quot_q;
  assign rem_o      = rem_q;
  assign div_zero_o = dz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and exhaustive checks of seq_divider with N=8, M=4.
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_i = 1'b0;
  logic [7:0] dividend_i = '0;
  logic [3:0] divisor_i = '0;
  logic       busy_o, done_o, div_zero_o;
  logic [7:0] quot_o;
  logic [3:0] rem_o;

  int n_checks = 0;
  int n_errors = 0;

  seq_divider #(
    .N (8),
    .M (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .quot_o     (quot_o),
    .rem_o      (rem_o),
    .div_zero_o (div_zero_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Launch one division; edges = clock edges from the start edge to the edge raising done.
  task automatic do_div(input logic [7:0] a, input logic [3:0] b,
                        output int edges, output int busy_cycles);
    busy_cycles = 0;
    edges       = -1;
    @(negedge clk);
    dividend_i = a;
    divisor_i  = b;
    start_i    = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy_o) busy_cycles++;
      if (done_o) begin
        edges = i;
        break;
      end
    end
  endtask

  logic [7:0] ext_a [5] = '{8'd255, 8'd255, 8'd5, 8'd0, 8'd200};
  logic [3:0] ext_b [5] = '{4'd15, 4'd1, 4'd15, 4'd9, 4'd7};
  logic [7:0] ext_q [5] = '{8'd17, 8'd255, 8'd0, 8'd0, 8'd28};
  logic [3:0] ext_r [5] = '{4'd0, 4'd0, 4'd5, 4'd0, 4'd4};

  initial begin
    int e, bc, dones, t0, t1, t2;
    logic [7:0] q0, q1, q2;
    logic [3:0] r0, r1, r2;
    logic [7:0] exp_q;
    logic [3:0] exp_r;
    logic       exp_z;

    #12;
    check("reset_busy", busy_o, 0);
    check("reset_done", done_o, 0);
    check("reset_quot", quot_o, 0);
    check("reset_rem", rem_o, 0);
    check("reset_dz", div_zero_o, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic 200/7 with latency and busy length
    do_div(8'd200, 4'd7, e, bc);
    check("basic_latency", e, 8);
    check("basic_busy", bc, 8);
    check("basic_quot", quot_o, 28);
    check("basic_rem", rem_o, 4);
    check("basic_dz", div_zero_o, 0);
    repeat (3) @(negedge clk);
    check("basic_done_pulse", done_o, 0);
    check("basic_hold", quot_o, 28);

    for (int i = 0; i < 5; i++) begin
      do_div(ext_a[i], ext_b[i], e, bc);
      check("ext_latency", e, 8);
      check("ext_quot", quot_o, {24'd0, ext_q[i]});
      check("ext_rem", rem_o, {28'd0, ext_r[i]});
    end

    // Division by zero then a normal division
    do_div(8'd123, 4'd0, e, bc);
    check("dz_latency", e, 0);
    check("dz_busy", bc, 0);
    check("dz_quot", quot_o, 255);
    check("dz_rem", rem_o, 0);
    check("dz_flag", div_zero_o, 1);
    do_div(8'd10, 4'd3, e, bc);
    check("after_dz_quot", quot_o, 3);
    check("after_dz_rem", rem_o, 1);
    check("after_dz_flag", div_zero_o, 0);

    // Start pulsed mid-CALC must be ignored
    @(negedge clk);
    dividend_i = 8'd100;
    divisor_i  = 4'd3;
    start_i    = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 2) begin
        dividend_i = 8'd50;
        divisor_i  = 4'd5;
        start_i    = 1'b1;
      end
      if (i == 3) start_i = 1'b0;
      if (done_o) dones++;
    end
    check("ign_dones", dones, 1);
    check("ign_quot", quot_o, 33);
    check("ign_rem", rem_o, 1);
    check("ign_busy", busy_o, 0);

    // Reset in the middle of CALC
    @(negedge clk);
    dividend_i = 8'd77;
    divisor_i  = 4'd6;
    start_i    = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_quot", quot_o, 0);
    check("rst_rem", rem_o, 0);
    check("rst_dz", div_zero_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done_o) dones++;
    end
    check("rst_no_done", dones, 0);
    do_div(8'd77, 4'd6, e, bc);
    check("rst_redo_quot", quot_o, 12);
    check("rst_redo_rem", rem_o, 5);

    // Back-to-back with start held high
    @(negedge clk);
    dividend_i = 8'd99;
    divisor_i  = 4'd10;
    start_i    = 1'b1;
    dones = 0;
    t0 = -1; t1 = -1; t2 = -1;
    q0 = '0; q1 = '0; q2 = '0;
    r0 = '0; r1 = '0; r2 = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_o) begin
        if (dones == 0) begin t0 = i; q0 = quot_o; r0 = rem_o; end
        if (dones == 1) begin t1 = i; q1 = quot_o; r1 = rem_o; end
        if (dones == 2) begin t2 = i; q2 = quot_o; r2 = rem_o; end
        dones++;
      end
    end
    start_i = 1'b0;
    check("b2b_gap1", t1 - t0, 10);
    check("b2b_gap2", t2 - t1, 10);
    check("b2b_q0", {q0, r0}, {8'd9, 4'd9});
    check("b2b_q1", {q1, r1}, {8'd9, 4'd9});
    check("b2b_q2", {q2, r2}, {8'd9, 4'd9});
    repeat (12) @(negedge clk);

    // Every operand pair against the integer model
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        do_div(a[7:0], b[3:0], e, bc);
        if (b == 0) begin
          exp_q = 8'hFF;
          exp_r = 4'd0;
          exp_z = 1'b1;
        end else begin
          exp_q = 8'(a / b);
          exp_r = 4'(a % b);
          exp_z = 1'b0;
        end
        check("sweep", {e[7:0], div_zero_o, quot_o, rem_o},
              {(b == 0) ? 8'd0 : 8'd8, exp_z, exp_q, exp_r});
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
